// File: rtl/bus_bridge_io.sv
// bus_bridge_io
//   Memory-mapped bridge sitting directly behind a single-cycle CPU core.
//   Splits the CPU bus between the data RAM and the on-board peripherals:
//   LEDs, switches, buttons, an 8-digit multiplexed 7-segment display and a
//   free-running cycle timer. Reads are combinational (same-cycle); writes
//   commit on the rising edge of cpu_clk.
// Ports
//   cpu_clk, cpu_rst        clock, asynchronous active-high reset
//   Bus_addr/we/wdata       CPU byte address, write strobe, write data
//   Bus_rdata               combinational read data to the CPU
//   dram_addr/we/wdata      data RAM word address, write enable, write data
//   dram_rdata              data RAM read data
//   sw, button              raw asynchronous switch / button levels
//   led                     LED drive, 1 = lit
//   dig_en, seg             active-low digit enables and segments {dp,g..a}
module bus_bridge_io #(
  parameter int SCAN_DIV = 20000,
  parameter int DRAM_AW  = 16,
  parameter int LED_W    = 24,
  parameter int SW_W     = 24
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_we,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [SW_W-1:0]    sw,
  input  logic [4:0]         button,
  output logic [LED_W-1:0]   led,
  output logic [7:0]         dig_en,
  output logic [7:0]         seg
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [11:0] OFF_DIG = 12'h000;
  localparam logic [11:0] OFF_TMR = 12'h020;
  localparam logic [11:0] OFF_LED = 12'h060;
  localparam logic [11:0] OFF_SW  = 12'h070;
  localparam logic [11:0] OFF_BTN = 12'h078;

  logic             periph_hit_s;
  logic [11:0]      offset_s;
  logic             wr_dig_s;
  logic             wr_tmr_s;
  logic             wr_led_s;
  logic [31:0]      rdata_s;

  logic [LED_W-1:0] led_r;
  logic [31:0]      dig_r;
  logic [31:0]      tmr_r;
  logic [SW_W-1:0]  sw_meta_r;
  logic [SW_W-1:0]  sw_sync_r;
  logic [4:0]       btn_meta_r;
  logic [4:0]       btn_sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       dig_en_r;
  logic [7:0]       seg_r;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one hex nibble, dp off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      4'hF:    pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // Address decode and peripheral write strobes.
  always_comb begin
    periph_hit_s = (Bus_addr[31:12] == 20'hFFFFF);
    offset_s     = Bus_addr[11:0];
    wr_dig_s     = Bus_we & periph_hit_s & (offset_s == OFF_DIG);
    wr_tmr_s     = Bus_we & periph_hit_s & (offset_s == OFF_TMR);
    wr_led_s     = Bus_we & periph_hit_s & (offset_s == OFF_LED);
  end

  // Same-cycle read mux; unmapped peripheral offsets read as zero.
  always_comb begin
    rdata_s = 32'd0;
    if (!periph_hit_s) begin
      rdata_s = dram_rdata;
    end else begin
      case (offset_s)
        OFF_DIG: rdata_s = dig_r;
        OFF_TMR: rdata_s = tmr_r;
        OFF_LED: rdata_s[LED_W-1:0] = led_r;
        OFF_SW:  rdata_s[SW_W-1:0]  = sw_sync_r;
        OFF_BTN: rdata_s[4:0]       = btn_sync_r;
        default: rdata_s = 32'd0;
      endcase
    end
  end

  assign Bus_rdata  = rdata_s;
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_we    = Bus_we & ~periph_hit_s;
  assign dram_wdata = Bus_wdata;
  assign led        = led_r;
  assign dig_en     = dig_en_r;
  assign seg        = seg_r;

  // LED and display value registers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_r <= {LED_W{1'b0}};
      dig_r <= 32'd0;
    end else begin
      if (wr_led_s) led_r <= Bus_wdata[LED_W-1:0];
      if (wr_dig_s) dig_r <= Bus_wdata;
    end
  end

  // Cycle timer; a CPU write takes priority over the increment.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      tmr_r <= 32'd0;
    end else if (wr_tmr_s) begin
      tmr_r <= Bus_wdata;
    end else begin
      tmr_r <= tmr_r + 32'd1;
    end
  end

  // Two-flop synchronisers for the asynchronous switch and button levels.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      sw_meta_r  <= {SW_W{1'b0}};
      sw_sync_r  <= {SW_W{1'b0}};
      btn_meta_r <= 5'd0;
      btn_sync_r <= 5'd0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= button;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Display scanner: hold each digit SCAN_DIV cycles; outputs lag idx by one cycle.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      idx_r     <= 3'd0;
      dig_en_r  <= 8'hFF;
      seg_r     <= 8'hFF;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= {DIV_W{1'b0}};
        idx_r     <= idx_r + 3'd1;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      dig_en_r <= ~(8'd1 << idx_r);
      seg_r    <= hex_to_seg(dig_r[{idx_r, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_bus_bridge_io.sv
// tb_bus_bridge_io
//   Self-checking bench for bus_bridge_io with a fast display scan.
//   A behavioural model tracks LED/DIG/timer contents, the switch/button
//   history and the number of cycles since reset release, from which the
//   expected display digit and pattern are derived arithmetically.
module tb_bus_bridge_io;
  localparam int SCAN_DIV = 4;
  localparam int DRAM_AW  = 16;
  localparam int LED_W    = 24;
  localparam int SW_W     = 24;

  logic               cpu_clk = 1'b0;
  logic               cpu_rst = 1'b1;
  logic [31:0]        Bus_addr = 32'd0;
  logic               Bus_we = 1'b0;
  logic [31:0]        Bus_wdata = 32'd0;
  logic [31:0]        Bus_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_we;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata = 32'd0;
  logic [SW_W-1:0]    sw = '0;
  logic [4:0]         button = 5'd0;
  logic [LED_W-1:0]   led;
  logic [7:0]         dig_en;
  logic [7:0]         seg;

  always #5 cpu_clk = ~cpu_clk;

  bus_bridge_io #(
    .SCAN_DIV(SCAN_DIV), .DRAM_AW(DRAM_AW), .LED_W(LED_W), .SW_W(SW_W)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .Bus_addr(Bus_addr), .Bus_we(Bus_we), .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .button(button), .led(led), .dig_en(dig_en), .seg(seg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]       seg_tab [16];
  int               n_edges;
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_dig;
  logic [31:0]      m_tmr;
  logic [SW_W-1:0]  sw_q[$];
  logic [4:0]       btn_q[$];
  logic [7:0]       exp_dig_en;
  logic [7:0]       exp_seg;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:12] != 20'hFFFFF) r = dram_rdata;
    else if (a[11:0] == 12'h000) r = m_dig;
    else if (a[11:0] == 12'h020) r = m_tmr;
    else if (a[11:0] == 12'h060) r = 32'(m_led);
    else if (a[11:0] == 12'h070) r = (sw_q.size() >= 2) ? 32'(sw_q[sw_q.size()-2]) : 32'd0;
    else if (a[11:0] == 12'h078) r = (btn_q.size() >= 2) ? 32'(btn_q[btn_q.size()-2]) : 32'd0;
    return r;
  endfunction

  task automatic model_reset();
    n_edges = 0;
    m_led = '0;
    m_dig = 32'd0;
    m_tmr = 32'd0;
    sw_q.delete();
    btn_q.delete();
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    Bus_addr  = a;
    Bus_we    = we;
    Bus_wdata = d;
  endtask

  // One clock: advance the model with what is presented at the edge, end at negedge.
  task automatic tick();
    int idx;
    @(posedge cpu_clk);
    n_edges++;
    idx = ((n_edges - 1) / SCAN_DIV) % 8;
    exp_dig_en = ~(8'd1 << idx);
    exp_seg = seg_tab[(m_dig >> (4 * idx)) & 32'hF];
    sw_q.push_back(sw);
    btn_q.push_back(button);
    if (Bus_we && Bus_addr[31:12] == 20'hFFFFF && Bus_addr[11:0] == 12'h000) m_dig = Bus_wdata;
    if (Bus_we && Bus_addr[31:12] == 20'hFFFFF && Bus_addr[11:0] == 12'h060) m_led = Bus_wdata[LED_W-1:0];
    if (Bus_we && Bus_addr[31:12] == 20'hFFFFF && Bus_addr[11:0] == 12'h020) m_tmr = Bus_wdata;
    else m_tmr = m_tmr + 32'd1;
    @(negedge cpu_clk);
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    drive(32'hFFFFF020, 1'b0, 32'd0);
    repeat (3) begin
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      checks += 4;
      if (led !== '0) begin errors++; $display("FAIL rst_led got %h exp 0", led); end
      if (dig_en !== 8'hFF) begin errors++; $display("FAIL rst_dig_en got %h exp FF", dig_en); end
      if (seg !== 8'hFF) begin errors++; $display("FAIL rst_seg got %h exp FF", seg); end
      if (Bus_rdata !== 32'd0) begin errors++; $display("FAIL rst_tmr got %h exp 0", Bus_rdata); end
    end
    cpu_rst = 1'b0;
    model_reset();
    tick();
    checks += 2;
    if (dig_en !== 8'hFE || dig_en !== exp_dig_en) begin errors++; $display("FAIL first_dig_en got %h exp FE", dig_en); end
    if (seg !== 8'hC0 || seg !== exp_seg) begin errors++; $display("FAIL first_seg got %h exp C0", seg); end
  endtask

  task automatic test_led();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'h00ABCDEF : $urandom;
      drive(32'hFFFFF060, 1'b1, v);
      #1;
      checks++;
      if (dram_we !== 1'b0) begin errors++; $display("FAIL led_dram_we got %b exp 0", dram_we); end
      tick();
      drive(32'hFFFFF060, 1'b0, 32'd0);
      #1;
      checks += 3;
      if (led !== v[LED_W-1:0]) begin errors++; $display("FAIL led_out got %h exp %h", led, v[LED_W-1:0]); end
      if (Bus_rdata !== {8'h00, v[23:0]}) begin errors++; $display("FAIL led_read got %h exp %h", Bus_rdata, {8'h00, v[23:0]}); end
      if (dram_we !== 1'b0) begin errors++; $display("FAIL led_rd_dram_we got %b exp 0", dram_we); end
      tick();
    end
  endtask

  task automatic test_scan();
    drive(32'hFFFFF000, 1'b1, 32'h12345678);
    tick();
    drive(32'h00000100, 1'b0, 32'd0);
    for (int i = 0; i < 72; i++) begin
      if (i == 45) drive(32'hFFFFF000, 1'b1, $urandom);
      else drive(32'h00000100, 1'b0, 32'd0);
      tick();
      checks += 2;
      if (dig_en !== exp_dig_en) begin errors++; $display("FAIL scan_dig_en cyc %0d got %h exp %h", i, dig_en, exp_dig_en); end
      if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg cyc %0d got %h exp %h", i, seg, exp_seg); end
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    drive(32'hFFFFF020, 1'b1, 32'hFFFFFFFE);
    tick();
    drive(32'hFFFFF020, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      v = (i == 0) ? 32'hFFFFFFFE : ((i == 1) ? 32'hFFFFFFFF : 32'd0);
      if (Bus_rdata !== v || Bus_rdata !== exp_read(Bus_addr)) begin
        errors++; $display("FAIL tmr_wrap step %0d got %h exp %h", i, Bus_rdata, v);
      end
      tick();
    end
    v = $urandom;
    drive(32'hFFFFF020, 1'b1, v);
    tick();
    drive(32'hFFFFF020, 1'b0, 32'd0);
    #1;
    checks++;
    if (Bus_rdata !== v) begin errors++; $display("FAIL tmr_load got %h exp %h", Bus_rdata, v); end
    tick();
  endtask

  task automatic test_dram();
    logic [LED_W-1:0] led_before;
    logic [31:0]      rd;
    drive(32'h00000010, 1'b1, 32'hDEADBEEF);
    #1;
    checks += 3;
    if (dram_we !== 1'b1) begin errors++; $display("FAIL dram_we got %b exp 1", dram_we); end
    if (dram_addr !== 16'd4) begin errors++; $display("FAIL dram_addr got %h exp 4", dram_addr); end
    if (dram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dram_wdata got %h exp DEADBEEF", dram_wdata); end
    tick();
    rd = $urandom;
    dram_rdata = rd;
    drive(32'h0001234C, 1'b0, 32'd0);
    #1;
    checks += 2;
    if (Bus_rdata !== rd) begin errors++; $display("FAIL dram_read got %h exp %h", Bus_rdata, rd); end
    if (dram_addr !== 16'h48D3) begin errors++; $display("FAIL dram_addr2 got %h exp 48D3", dram_addr); end
    tick();
    led_before = led;
    drive(32'hFFFFF0F0, 1'b1, 32'h5A5A5A5A);
    #1;
    checks += 2;
    if (Bus_rdata !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h exp 0", Bus_rdata); end
    if (dram_we !== 1'b0) begin errors++; $display("FAIL unmapped_dram_we got %b exp 0", dram_we); end
    tick();
    drive(32'hFFFFF000, 1'b0, 32'd0);
    #1;
    checks += 2;
    if (led !== led_before) begin errors++; $display("FAIL unmapped_led got %h exp %h", led, led_before); end
    if (Bus_rdata !== m_dig) begin errors++; $display("FAIL unmapped_dig got %h exp %h", Bus_rdata, m_dig); end
    tick();
  endtask

  task automatic test_sync();
    logic [31:0] v;
    sw = '0;
    button = 5'd0;
    drive(32'hFFFFF070, 1'b0, 32'd0);
    tick();
    tick();
    sw = 24'h000055;
    for (int i = 0; i < 4; i++) begin
      #1;
      v = (i < 2) ? 32'd0 : 32'h00000055;
      checks++;
      if (Bus_rdata !== v || Bus_rdata !== exp_read(Bus_addr)) begin
        errors++; $display("FAIL sw_sync step %0d got %h exp %h", i, Bus_rdata, v);
      end
      tick();
    end
    button = 5'h13;
    drive(32'hFFFFF078, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (Bus_rdata !== exp_read(Bus_addr)) begin
        errors++; $display("FAIL btn_sync step %0d got %h exp %h", i, Bus_rdata, exp_read(Bus_addr));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [11:0] off;
    logic        we;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: a = 32'hFFFFF000;
        1: a = 32'hFFFFF020;
        2: a = 32'hFFFFF060;
        3: a = 32'hFFFFF070;
        4: a = 32'hFFFFF078;
        5: begin
          off = 12'($urandom);
          if (off == 12'h000 || off == 12'h020 || off == 12'h060 || off == 12'h070 || off == 12'h078) off = 12'hF0C;
          a = {20'hFFFFF, off};
        end
        default: a = $urandom & 32'hFFFFEFFF;
      endcase
      we = ($urandom_range(0, 2) == 0);
      drive(a, we, $urandom);
      dram_rdata = $urandom;
      if ($urandom_range(0, 4) == 0) sw = SW_W'($urandom);
      if ($urandom_range(0, 4) == 0) button = 5'($urandom);
      #1;
      checks += 3;
      if (Bus_rdata !== exp_read(a)) begin errors++; $display("FAIL rnd_read %h got %h exp %h", a, Bus_rdata, exp_read(a)); end
      if (dram_we !== (we && a[31:12] != 20'hFFFFF)) begin errors++; $display("FAIL rnd_dram_we %h got %b", a, dram_we); end
      if (dram_addr !== a[17:2]) begin errors++; $display("FAIL rnd_dram_addr got %h exp %h", dram_addr, a[17:2]); end
      tick();
      checks += 3;
      if (led !== m_led) begin errors++; $display("FAIL rnd_led got %h exp %h", led, m_led); end
      if (dig_en !== exp_dig_en) begin errors++; $display("FAIL rnd_dig_en got %h exp %h", dig_en, exp_dig_en); end
      if (seg !== exp_seg) begin errors++; $display("FAIL rnd_seg got %h exp %h", seg, exp_seg); end
    end
  endtask

  task automatic test_reset_mid();
    drive(32'hFFFFF000, 1'b1, 32'h89ABCDEF);
    tick();
    drive(32'h00000000, 1'b0, 32'd0);
    repeat (6) tick();
    drive(32'hFFFFF060, 1'b1, 32'h00FFFFFF);
    #2;
    cpu_rst = 1'b1;
    #1;
    checks += 3;
    if (dig_en !== 8'hFF) begin errors++; $display("FAIL mid_rst_dig_en got %h exp FF", dig_en); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL mid_rst_seg got %h exp FF", seg); end
    if (led !== '0) begin errors++; $display("FAIL mid_rst_led got %h exp 0", led); end
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    checks++;
    if (led !== '0) begin errors++; $display("FAIL mid_rst_write got %h exp 0", led); end
    drive(32'hFFFFF000, 1'b0, 32'd0);
    #1;
    checks++;
    if (Bus_rdata !== 32'd0) begin errors++; $display("FAIL mid_rst_dig got %h exp 0", Bus_rdata); end
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    model_reset();
    tick();
    checks += 2;
    if (dig_en !== 8'hFE) begin errors++; $display("FAIL post_rst_dig_en got %h exp FE", dig_en); end
    if (seg !== 8'hC0) begin errors++; $display("FAIL post_rst_seg got %h exp C0", seg); end
  endtask

  initial begin
    seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
    seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
    seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
    seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
    model_reset();
    exp_dig_en = 8'hFF;
    exp_seg = 8'hFF;
    @(negedge cpu_clk);
    test_reset();
    test_led();
    test_scan();
    test_timer();
    test_dram();
    test_sync();
    test_random();
    test_reset_mid();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
